// File: rtl/gcd_pkg.sv
// Shared width and FSM state encoding for the GCD accelerator tile.
package gcd_pkg;

    localparam int GCD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } gcd_state_t;

endpackage

// File: rtl/gcd_unit_if.sv
// Request/response val-rdy channel pair between a producer/consumer and the GCD unit.
interface gcd_unit_if
    import gcd_pkg::*;
#(
    parameter int W = GCD_W
) ();

    logic [2*W-1:0] req_msg;
    logic           req_val;
    logic           req_rdy;
    logic [W-1:0]   resp_msg;
    logic           resp_val;
    logic           resp_rdy;

    modport master (
        output req_msg, req_val, resp_rdy,
        input  req_rdy, resp_msg, resp_val
    );

    modport slave (
        input  req_msg, req_val, resp_rdy,
        output req_rdy, resp_msg, resp_val
    );

endinterface

// File: rtl/gcd_unit_dpath.sv
// GCD datapath: a/b operand registers, less-than compare, zero detect and subtractor.
module gcd_unit_dpath
    import gcd_pkg::*;
#(
    parameter int W = GCD_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           i_load,
    input  logic           i_swap,
    input  logic           i_sub,
    input  logic [2*W-1:0] i_msg,
    output logic           o_a_lt_b,
    output logic           o_b_zero,
    output logic [W-1:0]   o_a
);

    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic [W-1:0] w_diff;

    assign w_diff   = r_a - r_b;
    assign o_a_lt_b = (r_a < r_b);
    assign o_b_zero = (r_b == '0);
    assign o_a      = r_a;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a <= '0;
            r_b <= '0;
        end else if (i_load) begin
            r_a <= i_msg[2*W-1:W];
            r_b <= i_msg[W-1:0];
        end else if (i_swap) begin
            // NOTE: non-blocking assignments read the old values, so this is a true swap.
            r_a <= r_b;
            r_b <= r_a;
        end else if (i_sub) begin
            r_a <= w_diff;
        end
    end

endmodule

// File: rtl/gcd_unit.sv
// GCD unit top: FSM and val/rdy handshake around the subtract/swap datapath.
// Optional GCD_PERF_CNT_EN adds a saturating busy_cycles counter of CALC cycles.
module gcd_unit
    import gcd_pkg::*;
#(
    parameter int W = GCD_W
) (
    input  logic         clk,
    input  logic         reset,
    gcd_unit_if.slave    bus
`ifdef GCD_PERF_CNT_EN
    ,
    output logic [W-1:0] busy_cycles
`endif
);

    gcd_state_t   r_state;
    gcd_state_t   w_next;
    logic         w_load;
    logic         w_calc;
    logic         w_swap;
    logic         w_sub;
    logic         w_a_lt_b;
    logic         w_b_zero;
    logic [W-1:0] w_a;

    assign w_load = (r_state == IDLE) && bus.req_val;
    assign w_calc = (r_state == CALC);
    assign w_swap = w_calc && w_a_lt_b;
    assign w_sub  = w_calc && !w_a_lt_b && !w_b_zero;

    always_comb begin
        // NOTE: default assignment first so no path leaves w_next unassigned (no latch).
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.req_val) w_next = CALC;
            CALC:    if (!w_a_lt_b && w_b_zero) w_next = DONE;
            DONE:    if (bus.resp_rdy) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    gcd_unit_dpath #(.W(W)) u_dpath (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load),
        .i_swap   (w_swap),
        .i_sub    (w_sub),
        .i_msg    (bus.req_msg),
        .o_a_lt_b (w_a_lt_b),
        .o_b_zero (w_b_zero),
        .o_a      (w_a)
    );

    // Outputs decode registered state only; no input-to-output combinational path.
    assign bus.req_rdy  = (r_state == IDLE);
    assign bus.resp_val = (r_state == DONE);
    assign bus.resp_msg = w_a;

`ifdef GCD_PERF_CNT_EN
    logic [W-1:0] r_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                        r_busy <= '0;
        else if (w_load)                  r_busy <= '0;
        else if (w_calc && r_busy != '1)  r_busy <= r_busy + W'(1);
    end

    assign busy_cycles = r_busy;
`endif

endmodule

// File: tb/tb_gcd_unit.sv
// Self-checking bench for gcd_unit: transaction-level model plus directed vectors.
module tb_gcd_unit;

    localparam int W     = gcd_pkg::GCD_W;
    localparam int LIMIT = 8000;

    typedef enum int {M_IDLE, M_CALC, M_DONE} m_state_t;

    logic clk;
    logic reset;

    gcd_unit_if #(.W(W)) bus ();
`ifdef GCD_PERF_CNT_EN
    logic [W-1:0] busy_cycles;
`endif

    gcd_unit #(.W(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef GCD_PERF_CNT_EN
        ,
        .busy_cycles (busy_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: bounded wait expired at %0t", name, $time);
    endtask

    // Reference: Euclid by remainder for the value.
    function automatic int m_gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Number of swap/subtract steps taken by the subtraction form of Euclid.
    function automatic int gcd_steps(input int a, input int b);
        int n = 0;
        int t;
        forever begin
            if (a < b) begin t = a; a = b; b = t; n++; end
            else if (b != 0) begin a = a - b; n++; end
            else break;
        end
        return n;
    endfunction

    // Transaction-level model: one request in flight, CALC lasts steps+1 cycles.
    m_state_t m_state;
    int       m_left;
    int       m_exp;
    int       m_busy;
    int       sb[$];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state <= M_IDLE;
            m_left  <= 0;
            m_busy  <= 0;
            sb.delete();
        end else begin
            case (m_state)
                M_IDLE: if (bus.req_val) begin
                    m_state <= M_CALC;
                    m_left  <= gcd_steps(int'(bus.req_msg[2*W-1:W]), int'(bus.req_msg[W-1:0])) + 1;
                    m_exp   <= m_gcd(int'(bus.req_msg[2*W-1:W]), int'(bus.req_msg[W-1:0]));
                    m_busy  <= 0;
                    sb.push_back(m_gcd(int'(bus.req_msg[2*W-1:W]), int'(bus.req_msg[W-1:0])));
                end
                M_CALC: begin
                    if (m_busy < (1 << W) - 1) m_busy <= m_busy + 1;
                    if (m_left == 1) m_state <= M_DONE;
                    m_left <= m_left - 1;
                end
                M_DONE: if (bus.resp_rdy) m_state <= M_IDLE;
                default: m_state <= M_IDLE;
            endcase
        end
    end

    // Per-cycle compare against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (cmp_en && !reset) begin
            check("req_rdy", 32'(bus.req_rdy), 32'(m_state == M_IDLE));
            check("resp_val", 32'(bus.resp_val), 32'(m_state == M_DONE));
            if (m_state == M_DONE) check("resp_msg", 32'(bus.resp_msg), 32'(m_exp));
`ifdef GCD_PERF_CNT_EN
            check("busy_cycles", 32'(busy_cycles), 32'(m_busy));
`endif
            if (bus.resp_val && bus.resp_rdy) begin
                if (sb.size() == 0) fail_now("unexpected_resp");
                else check("resp_order", 32'(bus.resp_msg), 32'(sb.pop_front()));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (m_state != M_IDLE && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (m_state != M_IDLE) fail_now("wait_idle");
    endtask

    // Issue one request and return the cycle count from acceptance to resp_val.
    task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
        wait_idle();
        @(negedge clk);
        bus.req_msg = {a, b};
        bus.req_val = 1'b1;
        @(posedge clk);
        #1 bus.req_val = 1'b0;
        lat = 0;
        while (!bus.resp_val && lat < LIMIT) begin
            @(posedge clk);
            #1 lat++;
        end
        if (!bus.resp_val) fail_now("resp_timeout");
    endtask

    logic [W-1:0] tab_a [8];
    logic [W-1:0] tab_b [8];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [W-1:0] va;
        logic [W-1:0] vb;

        tab_a = '{16'd48, 16'd65535, 16'd1071, 16'd1000, 16'd0,  16'd5, 16'd54321, 16'd65535};
        tab_b = '{16'd18, 16'd65535, 16'd462,  16'd1,    16'd5,  16'd0, 16'd12345, 16'd256};

        reset        = 1'b1;
        bus.req_val  = 1'b0;
        bus.req_msg  = '0;
        bus.resp_rdy = 1'b1;
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("rst_req_rdy", 32'(bus.req_rdy), 32'd1);
        check("rst_resp_val", 32'(bus.resp_val), 32'd0);
        check("rst_resp_msg", 32'(bus.resp_msg), 32'd0);
        cmp_en = 1'b1;

        // Pin the reference model with hand-computed values.
        check("ref_48_18", 32'(m_gcd(48, 18)), 32'd6);
        check("ref_1071_462", 32'(m_gcd(1071, 462)), 32'd21);
        check("ref_65535_1", 32'(m_gcd(65535, 1)), 32'd1);
        check("ref_steps_15_5", 32'(gcd_steps(15, 5)), 32'd4);

        run_one(16'd15, 16'd5, lat);
        check("lat_15_5", 32'(lat), 32'd5);
        check("msg_15_5", 32'(bus.resp_msg), 32'd5);
`ifdef GCD_PERF_CNT_EN
        repeat (4) @(negedge clk);
        check("busy_hold_15_5", 32'(busy_cycles), 32'd5);
`endif

        run_one(16'd0, 16'd0, lat);
        check("lat_0_0", 32'(lat), 32'd1);
        check("msg_0_0", 32'(bus.resp_msg), 32'd0);
        run_one(16'd0, 16'd27, lat);
        check("lat_0_27", 32'(lat), 32'd2);
        check("msg_0_27", 32'(bus.resp_msg), 32'd27);
        run_one(16'd27, 16'd0, lat);
        check("lat_27_0", 32'(lat), 32'd1);
        check("msg_27_0", 32'(bus.resp_msg), 32'd27);

        // Consumer stall in DONE.
        wait_idle();
        bus.resp_rdy = 1'b0;
        run_one(16'd48, 16'd18, lat);
        repeat (10) @(negedge clk);
        check("stall_resp_val", 32'(bus.resp_val), 32'd1);
        check("stall_resp_msg", 32'(bus.resp_msg), 32'd6);
        check("stall_req_rdy", 32'(bus.req_rdy), 32'd0);
        bus.resp_rdy = 1'b1;
        @(posedge clk);
        #1;
        check("release_req_rdy", 32'(bus.req_rdy), 32'd1);
        check("release_resp_val", 32'(bus.resp_val), 32'd0);

        // Abort a long calculation with reset.
        wait_idle();
        @(negedge clk);
        bus.req_msg = {16'd65535, 16'd1};
        bus.req_val = 1'b1;
        @(posedge clk);
        #1 bus.req_val = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_busy", 32'(bus.req_rdy), 32'd0);
        #1 reset = 1'b1;
        #1;
        check("abort_req_rdy", 32'(bus.req_rdy), 32'd1);
        check("abort_resp_val", 32'(bus.resp_val), 32'd0);
        @(negedge clk);
        #1 reset = 1'b0;
        repeat (5) @(negedge clk);
        run_one(16'd12, 16'd8, lat);
        check("msg_12_8", 32'(bus.resp_msg), 32'd4);

        // 100 back-to-back requests with req_val held high.
        wait_idle();
        for (int i = 0; i < 100; i++) begin
            if (i % 4 == 0) begin
                va = tab_a[(i / 4) % 8];
                vb = tab_b[(i / 4) % 8];
            end else begin
                va = W'((i * 97 + 13) & 16'h0FFF);
                vb = W'((i * 31 + 7) & 16'h03FF);
            end
            wait_idle();
            bus.req_msg = {va, vb};
            bus.req_val = 1'b1;
            @(negedge clk);
        end
        bus.req_val = 1'b0;
        wait_idle();
        repeat (2) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
